// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 pipeline hazard scheduler:
// opcodes, FSM/forwarding encodings, the shadow-slot record and source-match helpers.
package riscv_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        REG   = 2'b00,
        EXMEM = 2'b10,
        MEMWB = 2'b01
    } fwd_sel_e;

    // Sources are stored already masked: an unused operand is recorded as x0.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } shadow_slot_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R_TYPE) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_ADDI)   || (op == OP_LW);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R_TYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic fwd_sel_e fwd_pick(input logic [4:0] rs, input shadow_slot_t mem,
                                          input shadow_slot_t wb);
        if (mem.reg_write && mem.rd != 5'd0 && mem.rd == rs) return EXMEM;
        if (wb.reg_write && wb.rd != 5'd0 && wb.rd == rs)     return MEMWB;
        return REG;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones, clears on reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard scheduler for the 5-stage RV32 pipeline: load-use/RAW stalls, branch flushes.
// Define FWD_EN to enable EX operand forwarding (only load-use then stalls).
module pipeline_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int FLUSH_EXTRA = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             id_mem_read,
    input  logic             id_reg_write,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e    state_q, state_d;
    logic [2:0]   fcnt_q, fcnt_d;
    shadow_slot_t ex_q, ex_d, mem_q, wb_q;

    logic [6:0] id_op;
    logic [4:0] id_src1, id_src2;
    logic       hazard;

    assign id_op   = id_instr[6:0];
    assign id_src1 = uses_rs1(id_op) ? id_instr[19:15] : 5'd0;
    assign id_src2 = uses_rs2(id_op) ? id_instr[24:20] : 5'd0;

`ifdef FWD_EN
    assign hazard = ex_q.mem_read && src_hit(ex_q.rd, id_src1, id_src2);
    assign fwd_a  = fwd_pick(ex_q.rs1, mem_q, wb_q);
    assign fwd_b  = fwd_pick(ex_q.rs2, mem_q, wb_q);
`else
    // WB writes the regfile before ID reads it, so only EX and MEM producers stall.
    assign hazard = (ex_q.reg_write  && src_hit(ex_q.rd,  id_src1, id_src2)) ||
                    (mem_q.reg_write && src_hit(mem_q.rd, id_src1, id_src2));
    assign fwd_a  = REG;
    assign fwd_b  = REG;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_d     = RUN;
        fcnt_d      = fcnt_q;

        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fcnt_d      = 3'(FLUSH_EXTRA);
            state_d     = (FLUSH_EXTRA > 0) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fcnt_d      = fcnt_q - 3'd1;
            state_d     = (fcnt_q <= 3'd1) ? RUN : FLUSH;
        end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = STALL;
        end
    end

    always_comb begin
        ex_d = '0;
        if (!idex_bubble) begin
            ex_d.rd        = id_instr[11:7];
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.rs1       = id_src1;
            ex_d.rs2       = id_src2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
        end
    end

    assign state_o = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_flush),
        .count (flush_cnt)
    );

    // Fields not consumed in every build configuration.
    logic unused_bits;
    assign unused_bits = ^{id_instr[31:25], id_instr[14:12], ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (FLUSH_EXTRA=2); expectations track FWD_EN.
module tb_pipeline_hazard_ctrl;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_ADDI = 7'b0010011;
    localparam logic [31:0] T_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic        id_mem_read = 1'b0;
    logic        id_reg_write = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b, state_o;
    logic [15:0] stall_cnt, flush_cnt;

    int n_pass = 0;
    int n_total = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .FLUSH_EXTRA(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_instr        (id_instr),
        .id_mem_read     (id_mem_read),
        .id_reg_write    (id_reg_write),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .state_o         (state_o),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    // Drive one ID-stage cycle on the falling edge; outputs are sampled 1 ns later.
    task automatic cyc(input logic [31:0] ins, input logic mr, input logic rw, input logic br);
        @(negedge clk);
        id_instr        = ins;
        id_mem_read     = mr;
        id_reg_write    = rw;
        ex_branch_taken = br;
        #1;
    endtask

    task automatic drain();
        repeat (4) cyc(T_NOP, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (pc_write !== 1'b1) $display("FAIL rst_pc_write got %b exp 1", pc_write); else n_pass++;
        n_total++; if (ifid_write !== 1'b1) $display("FAIL rst_ifid_write got %b exp 1", ifid_write); else n_pass++;
        n_total++; if ({ifid_flush, idex_bubble} !== 2'b00) $display("FAIL rst_flush_bubble got %b exp 00", {ifid_flush, idex_bubble}); else n_pass++;
        n_total++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL rst_fwd got %b exp 0000", {fwd_a, fwd_b}); else n_pass++;
        n_total++; if (state_o !== 2'd0) $display("FAIL rst_state got %0d exp 0", state_o); else n_pass++;
        n_total++; if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL rst_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        int n_st = FWD ? 1 : 2;
        cyc(mk(T_LW, 5'd5, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
        n_total++; if (pc_write !== 1'b1) $display("FAIL lu_lw_issue pc_write got %b exp 1", pc_write); else n_pass++;
        cyc(mk(T_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < n_st; i++) begin
            n_total++; if ({pc_write, ifid_write, idex_bubble} !== 3'b001) $display("FAIL lu_stall%0d pc/ifid/bubble got %b exp 001", i, {pc_write, ifid_write, idex_bubble}); else n_pass++;
            exp_stall++;
            cyc(mk(T_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1, 1'b0);
        end
        n_total++; if (pc_write !== 1'b1) $display("FAIL lu_release pc_write got %b exp 1", pc_write); else n_pass++;
        cyc(T_NOP, 1'b0, 1'b1, 1'b0);
        n_total++; if ({fwd_a, fwd_b} !== {(FWD ? 2'b01 : 2'b00), 2'b00}) $display("FAIL lu_fwd got %b exp %b", {fwd_a, fwd_b}, {(FWD ? 2'b01 : 2'b00), 2'b00}); else n_pass++;
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); else n_pass++;
        drain();
    endtask

    task automatic test_alu_raw();
        int n_st = FWD ? 0 : 2;
        cyc(mk(T_ADDI, 5'd5, 5'd0, 5'd7), 1'b0, 1'b1, 1'b0);
        cyc(mk(T_R, 5'd6, 5'd5, 5'd5), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < n_st; i++) begin
            n_total++; if (pc_write !== 1'b0) $display("FAIL raw_stall%0d pc_write got %b exp 0", i, pc_write); else n_pass++;
            exp_stall++;
            cyc(mk(T_R, 5'd6, 5'd5, 5'd5), 1'b0, 1'b1, 1'b0);
        end
        n_total++; if (pc_write !== 1'b1) $display("FAIL raw_release pc_write got %b exp 1", pc_write); else n_pass++;
        cyc(T_NOP, 1'b0, 1'b1, 1'b0);
        n_total++; if ({fwd_a, fwd_b} !== (FWD ? 4'b1010 : 4'b0000)) $display("FAIL raw_fwd got %b exp %b", {fwd_a, fwd_b}, (FWD ? 4'b1010 : 4'b0000)); else n_pass++;
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL raw_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); else n_pass++;
        drain();
    endtask

    task automatic test_x0();
        cyc(mk(T_LW, 5'd0, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
        cyc(mk(T_R, 5'd6, 5'd0, 5'd0), 1'b0, 1'b1, 1'b0);
        n_total++; if (pc_write !== 1'b1) $display("FAIL x0_no_stall pc_write got %b exp 1", pc_write); else n_pass++;
        cyc(T_NOP, 1'b0, 1'b1, 1'b0);
        n_total++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL x0_fwd got %b exp 0000", {fwd_a, fwd_b}); else n_pass++;
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL x0_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); else n_pass++;
        drain();
    endtask

    task automatic test_branch_priority();
        cyc(mk(T_LW, 5'd5, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
        cyc(mk(T_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1, 1'b1);
        n_total++; if ({pc_write, ifid_flush, idex_bubble} !== 3'b111) $display("FAIL br_resolve pc/flush/bubble got %b exp 111", {pc_write, ifid_flush, idex_bubble}); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cyc(T_NOP, 1'b0, 1'b1, 1'b0);
            n_total++; if ({pc_write, ifid_flush, idex_bubble} !== 3'b111) $display("FAIL br_extra%0d pc/flush/bubble got %b exp 111", i, {pc_write, ifid_flush, idex_bubble}); else n_pass++;
            n_total++; if (state_o !== 2'd2) $display("FAIL br_extra%0d_state got %0d exp 2", i, state_o); else n_pass++;
        end
        cyc(T_NOP, 1'b0, 1'b1, 1'b0);
        n_total++; if ({ifid_flush, idex_bubble} !== 2'b00) $display("FAIL br_done flush/bubble got %b exp 00", {ifid_flush, idex_bubble}); else n_pass++;
        n_total++; if (state_o !== 2'd0) $display("FAIL br_done_state got %0d exp 0", state_o); else n_pass++;
        n_total++; if (flush_cnt !== 16'd3) $display("FAIL br_flush_cnt got %0d exp 3", flush_cnt); else n_pass++;
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL br_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); else n_pass++;
        drain();
    endtask

    task automatic test_rs2_use();
        int n_st = FWD ? 1 : 2;
        cyc(mk(T_LW, 5'd5, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
        cyc(mk(T_SW, 5'd0, 5'd1, 5'd5), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n_st; i++) begin
            n_total++; if (pc_write !== 1'b0) $display("FAIL sw_rs2_stall%0d pc_write got %b exp 0", i, pc_write); else n_pass++;
            exp_stall++;
            cyc(mk(T_SW, 5'd0, 5'd1, 5'd5), 1'b0, 1'b0, 1'b0);
        end
        n_total++; if (pc_write !== 1'b1) $display("FAIL sw_release pc_write got %b exp 1", pc_write); else n_pass++;
        drain();
        // The addi immediate's low bits equal the load's rd, but ADDI has no rs2.
        cyc(mk(T_LW, 5'd9, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
        cyc(mk(T_ADDI, 5'd7, 5'd5, 5'd9), 1'b0, 1'b1, 1'b0);
        n_total++; if (pc_write !== 1'b1) $display("FAIL addi_no_rs2 pc_write got %b exp 1", pc_write); else n_pass++;
        cyc(T_NOP, 1'b0, 1'b1, 1'b0);
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL rs2_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); else n_pass++;
        drain();
    endtask

    task automatic test_async_reset();
        cyc(mk(T_LW, 5'd5, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
        cyc(mk(T_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1, 1'b0);
        n_total++; if (pc_write !== 1'b0) $display("FAIL ar_stall pc_write got %b exp 0", pc_write); else n_pass++;
        cyc(mk(T_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1, 1'b0);
        n_total++; if (state_o !== 2'd1) $display("FAIL ar_in_stall state got %0d exp 1", state_o); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (state_o !== 2'd0) $display("FAIL ar_state got %0d exp 0", state_o); else n_pass++;
        n_total++; if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b1100) $display("FAIL ar_outputs got %b exp 1100", {pc_write, ifid_write, ifid_flush, idex_bubble}); else n_pass++;
        n_total++; if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL ar_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (pc_write !== 1'b1) $display("FAIL ar_no_stale pc_write got %b exp 1", pc_write); else n_pass++;
        cyc(T_NOP, 1'b0, 1'b1, 1'b0);
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL ar_stall_cnt got %0d exp 0", stall_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_raw();
        test_x0();
        test_branch_priority();
        test_rs2_use();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
